// File: rtl/xadc_drp_arbiter.sv
// Arbitrates the XADC DRP port between Wishbone and a periodic four-channel status poller.
// Define XADC_DRP_TIMEOUT_EN to bound each DRP wait to TIMEOUT cycles (Wishbone side reports wb_err_o).
module xadc_drp_arbiter #(
  parameter int POLL_PERIOD = 100000,
  parameter int TIMEOUT     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [6:0]  drp_daddr_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  output logic [15:0] temp_o,
  output logic [15:0] vccint_o,
  output logic [15:0] vccaux_o,
  output logic [15:0] vbram_o,
  output logic        poll_done_o,
  output logic        poll_overrun_o
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] PERIOD_RELOAD = PW'(POLL_PERIOD - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WB_WAIT   = 2'd1;
  localparam logic [1:0] POLL_WAIT = 2'd2;
  localparam logic [1:0] WB_ACK    = 2'd3;

  function automatic logic [6:0] chan_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    chan_addr = 7'h00;
      2'd1:    chan_addr = 7'h01;
      2'd2:    chan_addr = 7'h02;
      default: chan_addr = 7'h06;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] period_q, period_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          den_q, den_d;
  logic          dwe_q, dwe_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [15:0]   di_q, di_d;
  logic [15:0]   dat_q, dat_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic [15:0]   cache_q [4];
  logic [15:0]   cache_d [4];
  logic          poll_advance;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`endif

  // Byte-lane selects and address/data bits outside the DRP window carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:9], wb_adr_i[1:0], wb_dat_i[31:16]};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    period_d     = period_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    den_d        = 1'b0;
    dwe_d        = dwe_q;
    daddr_d      = daddr_q;
    di_d         = di_q;
    dat_d        = dat_q;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    cache_d      = cache_q;
    poll_advance = 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
    err_d        = 1'b0;
    wait_d       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          den_d   = 1'b1;
          daddr_d = wb_adr_i[8:2];
          dwe_d   = wb_we_i;
          di_d    = wb_dat_i[15:0];
          state_d = WB_WAIT;
        end else if (pending_q) begin
          den_d   = 1'b1;
          daddr_d = chan_addr(idx_q);
          dwe_d   = 1'b0;
          di_d    = 16'h0000;
          state_d = POLL_WAIT;
        end
      end
      WB_WAIT: begin
        if (drp_drdy_i) begin
          dat_d   = drp_do_i;
          ack_d   = 1'b1;
          state_d = WB_ACK;
        end
`ifdef XADC_DRP_TIMEOUT_EN
        else if (wait_q == WW'(TIMEOUT - 1)) begin
          dat_d   = 16'h0000;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
      POLL_WAIT: begin
        if (drp_drdy_i) begin
          cache_d[idx_q] = drp_do_i;
          poll_advance   = 1'b1;
        end
`ifdef XADC_DRP_TIMEOUT_EN
        else if (wait_q == WW'(TIMEOUT - 1)) begin
          poll_advance = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (poll_advance) begin
      idx_d   = idx_q + 2'd1;
      state_d = IDLE;
      if (idx_q == 2'd3) begin
        pending_d = 1'b0;
        done_d    = 1'b1;
      end
    end

    // Evaluated after the FSM so a new period start wins over a sweep completing in the same cycle.
    if (period_q == '0) begin
      period_d  = PERIOD_RELOAD;
      pending_d = 1'b1;
      if (pending_q) begin
        overrun_d = 1'b1;
      end
    end else begin
      period_d = period_q - PW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      period_q  <= PERIOD_RELOAD;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= 7'h00;
      di_q      <= 16'h0000;
      dat_q     <= 16'h0000;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      cache_q   <= '{default: 16'h0000};
`ifdef XADC_DRP_TIMEOUT_EN
      wait_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      cache_q   <= cache_d;
`ifdef XADC_DRP_TIMEOUT_EN
      wait_q    <= wait_d;
      err_q     <= err_d;
`endif
    end
  end

  assign wb_dat_o       = {16'h0000, dat_q};
  assign wb_ack_o       = ack_q;
`ifdef XADC_DRP_TIMEOUT_EN
  assign wb_err_o       = err_q;
`else
  assign wb_err_o       = 1'b0;
`endif
  assign drp_daddr_o    = daddr_q;
  assign drp_den_o      = den_q;
  assign drp_dwe_o      = dwe_q;
  assign drp_di_o       = di_q;
  assign temp_o         = cache_q[0];
  assign vccint_o       = cache_q[1];
  assign vccaux_o       = cache_q[2];
  assign vbram_o        = cache_q[3];
  assign poll_done_o    = done_q;
  assign poll_overrun_o = overrun_q;

endmodule
